// File: rtl/program_loader_if.sv
// program_loader_if -- byte-stream handshake and instruction-memory write bus.
//   byteValid/byteData : program byte stream from the source
//   byteReady          : loader accepts byteData this cycle
//   wrAddr/wrData/wrEn : single-cycle instruction-memory write port
// Modports: master = stream source / memory side, slave = loader side.
interface program_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
);
    logic              byteValid;
    logic [7:0]        byteData;
    logic              byteReady;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              wrEn;

    modport master (
        output byteValid, byteData,
        input  byteReady, wrAddr, wrData, wrEn
    );

    modport slave (
        input  byteValid, byteData,
        output byteReady, wrAddr, wrData, wrEn
    );
endinterface

// File: rtl/program_loader.sv
// program_loader -- receives a length-prefixed, XOR-checksummed byte stream and
// writes it into instruction memory as DATA_W-bit words while holding the core
// in reset until a load completes with a good checksum.
//   clk, reset : clock and synchronous active-high reset
//   start      : one-cycle request to begin a load (honoured in IDLE/DONE/ERROR)
//   bus        : byte stream handshake and instruction-memory write port
//   cpuReset   : core reset, low only in DONE
//   busy       : load in progress
//   done       : last load completed with good checksum
//   error      : last load failed (length or checksum)
module program_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 24,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    program_loader_if.slave   bus,
    output logic              cpuReset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t            state, state_nx;
    logic [15:0]       length;
    logic [15:0]       word_idx;
    logic [DATA_W-1:0] word_reg;
    logic [1:0]        byte_cnt;
    logic [7:0]        csum;
    logic              ready;
    logic              accept;
    logic              load_start;
    logic [15:0]       len_full;

    assign ready    = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == DATA)   || (state == CHECK);
    assign accept   = bus.byteValid && ready;
    // Full length as it will be once the low byte is captured.
    assign len_full = {length[15:8], bus.byteData};

    assign bus.byteReady = ready;
    assign bus.wrEn      = (state == WRITE);
    assign bus.wrAddr    = ADDR_W'(word_idx);
    assign bus.wrData    = word_reg;
    assign busy          = ready || (state == WRITE);
    assign done          = (state == DONE);
    assign error         = (state == ERROR);
    assign cpuReset      = (state != DONE);

    always_comb begin
        state_nx   = state;
        load_start = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nx   = LEN_HI;
                    load_start = 1'b1;
                end
            end
            LEN_HI: if (accept) state_nx = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)
                        state_nx = CHECK;
                    else if (len_full > 16'(MAX_WORDS))
                        state_nx = ERROR;
                    else
                        state_nx = DATA;
                end
            end
            DATA: if (accept && byte_cnt == 2'd2) state_nx = WRITE;
            WRITE: begin
                if (16'(word_idx + 16'd1) == length)
                    state_nx = CHECK;
                else
                    state_nx = DATA;
            end
            CHECK: begin
                if (accept)
                    state_nx = (bus.byteData == csum) ? DONE : ERROR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            length   <= '0;
            word_idx <= '0;
            word_reg <= '0;
            byte_cnt <= '0;
            csum     <= '0;
        end else begin
            state <= state_nx;
            if (load_start) begin
                length   <= '0;
                word_idx <= '0;
                word_reg <= '0;
                byte_cnt <= '0;
                csum     <= '0;
            end
            case (state)
                LEN_HI: if (accept) length[15:8] <= bus.byteData;
                LEN_LO: if (accept) length[7:0]  <= bus.byteData;
                DATA: begin
                    if (accept) begin
                        word_reg <= {word_reg[DATA_W-9:0], bus.byteData};
                        csum     <= csum ^ bus.byteData;
                        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : 2'(byte_cnt + 2'd1);
                    end
                end
                WRITE: word_idx <= 16'(word_idx + 16'd1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader -- directed self-checking bench for program_loader.
// Drives bytes on the falling edge, samples outputs on the falling edge, and
// logs every wrEn pulse into queues compared against hand-computed writes.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpuReset, busy, done, error;

    int checks   = 0;
    int failures = 0;

    logic [15:0] wr_addr_q[$];
    logic [23:0] wr_data_q[$];
    logic [7:0]  stim[$];

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(16), .DATA_W(24)) bus ();

    program_loader #(.ADDR_W(16), .DATA_W(24), .MAX_WORDS(1024)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpuReset (cpuReset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    // Write monitor: WRITE lasts one cycle, so one falling edge sees each pulse.
    always @(negedge clk) begin
        if (bus.wrEn === 1'b1) begin
            wr_addr_q.push_back(bus.wrAddr);
            wr_data_q.push_back(bus.wrData);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        start         = 1'b0;
        bus.byteValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Keeps byteValid high with a junk byte while the loader is not ready,
    // then presents b so it is accepted on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.byteReady && n < 50) begin
            bus.byteValid = 1'b1;
            bus.byteData  = 8'hEE;
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd1, 32'd0);
        bus.byteValid = 1'b1;
        bus.byteData  = b;
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus.byteValid = 1'b0;
        bus.byteData  = 8'h00;
    endtask

    // Sends stim; start is also held high from byte index start_at onward
    // for two accepted bytes (used to show start is ignored mid-load).
    task automatic run_stim(input int start_at);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            start = (i == start_at || i == start_at + 1) ? 1'b1 : 1'b0;
        end
        end_stream();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Two-word load; XOR of 12 34 56 AB CD EF is 0xF9.
    task automatic good_two_word(input string tag, input int start_at);
        clear_log();
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hF9};
        run_stim(start_at);
        wait_idle();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_cpuReset"}, 32'(cpuReset), 32'd0);
        check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check({tag, "_addr0"}, 32'(wr_addr_q[0]), 32'h0);
            check({tag, "_data0"}, 32'(wr_data_q[0]), 32'h123456);
            check({tag, "_addr1"}, 32'(wr_addr_q[1]), 32'h1);
            check({tag, "_data1"}, 32'(wr_data_q[1]), 32'hABCDEF);
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        bus.byteValid = 1'b0;
        bus.byteData  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_byteReady", 32'(bus.byteReady), 32'd0);
        check("rst_wrEn", 32'(bus.wrEn), 32'd0);
        check("rst_wrAddr", 32'(bus.wrAddr), 32'd0);
        check("rst_wrData", 32'(bus.wrData), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cpuReset", 32'(cpuReset), 32'd1);
        reset = 1'b0;

        // Good two-word load.
        good_two_word("good", -10);

        // Same stream, wrong checksum.
        clear_log();
        pulse_start();
        check("badck_clears_done", 32'(done), 32'd0);
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h00};
        run_stim(-10);
        wait_idle();
        check("badck_error", 32'(error), 32'd1);
        check("badck_done", 32'(done), 32'd0);
        check("badck_cpuReset", 32'(cpuReset), 32'd1);
        check("badck_nwr", 32'(wr_addr_q.size()), 32'd2);

        // Oversized lengths.
        clear_log();
        pulse_start();
        stim = '{8'hFF, 8'hFF};
        run_stim(-10);
        check("lenFFFF_error", 32'(error), 32'd1);
        check("lenFFFF_busy", 32'(busy), 32'd0);
        check("lenFFFF_nwr", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();
        stim = '{8'h04, 8'h01};
        run_stim(-10);
        check("len1025_error", 32'(error), 32'd1);

        // Exactly MAX_WORDS is accepted: loader waits for data.
        pulse_start();
        stim = '{8'h04, 8'h00};
        run_stim(-10);
        check("len1024_error", 32'(error), 32'd0);
        check("len1024_ready", 32'(bus.byteReady), 32'd1);
        do_reset();

        // Empty program, then a one-word program (01^02^03 = 00).
        clear_log();
        pulse_start();
        stim = '{8'h00, 8'h00, 8'h00};
        run_stim(-10);
        check("empty_done", 32'(done), 32'd1);
        check("empty_nwr", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();
        stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
        run_stim(-10);
        wait_idle();
        check("one_done", 32'(done), 32'd1);
        check("one_nwr", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("one_addr0", 32'(wr_addr_q[0]), 32'h0);
            check("one_data0", 32'(wr_data_q[0]), 32'h010203);
        end

        // Start held during the 2nd and 3rd data bytes must be ignored.
        good_two_word("midstart", 3);

        // Reset after the second data byte of a load.
        clear_log();
        pulse_start();
        stim = '{8'h00, 8'h02, 8'h12, 8'h34};
        run_stim(-10);
        reset         = 1'b1;
        start         = 1'b1;
        bus.byteValid = 1'b1;
        bus.byteData  = 8'h56;
        @(negedge clk);
        check("midrst_byteReady", 32'(bus.byteReady), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wrEn", 32'(bus.wrEn), 32'd0);
        check("midrst_wrAddr", 32'(bus.wrAddr), 32'd0);
        check("midrst_wrData", 32'(bus.wrData), 32'd0);
        check("midrst_cpuReset", 32'(cpuReset), 32'd1);
        reset         = 1'b0;
        start         = 1'b0;
        bus.byteValid = 1'b0;
        @(negedge clk);
        check("postrst_wrEn", 32'(bus.wrEn), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_nwr", 32'(wr_addr_q.size()), 32'd0);
        good_two_word("afterrst", -10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
